// File: rtl/avalon_mem_if_pipe.sv
// Avalon-MM pipeline stage between an AFU and the FIU: 2-entry in-order command
// buffer, read-beat credit limiting, and a registered read-response path.
module avalon_mem_if_pipe #(
    parameter int ADDR_WIDTH       = 27,
    parameter int DATA_WIDTH       = 512,
    parameter int BURST_CNT_WIDTH  = 7,
    parameter int MAX_ACTIVE_BEATS = 256
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [ADDR_WIDTH-1:0]                     afu_address,
    input  logic [BURST_CNT_WIDTH-1:0]                afu_burstcount,
    input  logic [DATA_WIDTH-1:0]                     afu_writedata,
    input  logic [DATA_WIDTH/8-1:0]                   afu_byteenable,
    input  logic                                      afu_read,
    input  logic                                      afu_write,
    output logic                                      afu_waitrequest,
    output logic [DATA_WIDTH-1:0]                     afu_readdata,
    output logic                                      afu_readdatavalid,
    output logic [ADDR_WIDTH-1:0]                     fiu_address,
    output logic [BURST_CNT_WIDTH-1:0]                fiu_burstcount,
    output logic [DATA_WIDTH-1:0]                     fiu_writedata,
    output logic [DATA_WIDTH/8-1:0]                   fiu_byteenable,
    output logic                                      fiu_read,
    output logic                                      fiu_write,
    input  logic                                      fiu_waitrequest,
    input  logic [DATA_WIDTH-1:0]                     fiu_readdata,
    input  logic                                      fiu_readdatavalid,
    output logic [$clog2(MAX_ACTIVE_BEATS+1)-1:0]     outstanding_beats,
    output logic                                      err_rsp_underflow
);

    localparam int OW        = $clog2(MAX_ACTIVE_BEATS + 1);
    localparam int OW1       = OW + 1;
    localparam int BE_W      = DATA_WIDTH / 8;
    localparam int MAX_BURST = 2 ** (BURST_CNT_WIDTH - 1);

    generate
        if (MAX_ACTIVE_BEATS < MAX_BURST) begin : g_bad_cfg
            $error("MAX_ACTIVE_BEATS must be at least the largest legal burst");
        end
    endgenerate

    typedef struct packed {
        logic                       rd;
        logic                       wr;
        logic [ADDR_WIDTH-1:0]      addr;
        logic [BURST_CNT_WIDTH-1:0] bc;
        logic [DATA_WIDTH-1:0]      wdata;
        logic [BE_W-1:0]            be;
    } cmd_t;

    cmd_t                  r_buf [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  r_waitreq;
    logic [OW-1:0]         r_outstanding;
    logic                  r_err;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;

    cmd_t                  w_head;
    logic                  w_head_vld;
    logic [OW1-1:0]        w_need;
    logic                  w_credit_ok;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_rd_acc;
    logic                  w_dec;
    logic [1:0]            w_count_nxt;
    logic [OW-1:0]         w_add;

    assign w_head      = r_buf[r_rd_ptr];
    assign w_head_vld  = (r_count != 2'd0);
    // Credit only grows while a read head waits, so once asserted fiu_read stays up.
    assign w_need      = {1'b0, r_outstanding} + OW1'(w_head.bc);
    assign w_credit_ok = (w_need <= OW1'(MAX_ACTIVE_BEATS));

    assign fiu_read       = !reset && w_head_vld && w_head.rd && w_credit_ok;
    assign fiu_write      = !reset && w_head_vld && w_head.wr;
    assign fiu_address    = w_head.addr;
    assign fiu_burstcount = w_head.bc;
    assign fiu_writedata  = w_head.wdata;
    assign fiu_byteenable = w_head.be;

    assign w_push      = (afu_read || afu_write) && !r_waitreq;
    assign w_pop       = (fiu_read || fiu_write) && !fiu_waitrequest;
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
    assign w_rd_acc    = fiu_read && !fiu_waitrequest;
    assign w_add       = w_rd_acc ? OW'(w_head.bc) : '0;
    assign w_dec       = fiu_readdatavalid && (r_outstanding != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count       <= 2'd0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_waitreq     <= 1'b1;
            r_outstanding <= '0;
            r_err         <= 1'b0;
            r_rvalid      <= 1'b0;
        end else begin
            r_count       <= w_count_nxt;
            r_waitreq     <= (w_count_nxt == 2'd2);
            r_outstanding <= r_outstanding + w_add - OW'(w_dec);
            r_rvalid      <= fiu_readdatavalid;
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            if (fiu_readdatavalid && (r_outstanding == '0)) r_err <= 1'b1;
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wr_ptr] <= {afu_read, afu_write, afu_address, afu_burstcount,
                                afu_writedata, afu_byteenable};
        end
        r_rdata <= fiu_readdata;
    end

    assign afu_waitrequest   = r_waitreq;
    assign afu_readdata      = r_rdata;
    assign afu_readdatavalid = r_rvalid;
    assign outstanding_beats = r_outstanding;
    assign err_rsp_underflow = r_err;

endmodule

// File: tb/tb_avalon_mem_if_pipe.sv
// Self-checking bench for avalon_mem_if_pipe: directed scenarios plus a randomized
// run against a queue-based model of the command buffer and read-credit rules.
module tb_avalon_mem_if_pipe;

    localparam int AW   = 27;
    localparam int DW   = 64;
    localparam int BW   = 7;
    localparam int MAXB = 64;
    localparam int OW   = $clog2(MAXB + 1);

    typedef struct {
        bit             rd;
        bit             wr;
        logic [AW-1:0]  addr;
        logic [BW-1:0]  bc;
        logic [DW-1:0]  wd;
        logic [DW/8-1:0] be;
    } cmd_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [AW-1:0]    afu_address = '0;
    logic [BW-1:0]    afu_burstcount = '0;
    logic [DW-1:0]    afu_writedata = '0;
    logic [DW/8-1:0]  afu_byteenable = '0;
    logic             afu_read = 1'b0;
    logic             afu_write = 1'b0;
    logic             afu_waitrequest;
    logic [DW-1:0]    afu_readdata;
    logic             afu_readdatavalid;
    logic [AW-1:0]    fiu_address;
    logic [BW-1:0]    fiu_burstcount;
    logic [DW-1:0]    fiu_writedata;
    logic [DW/8-1:0]  fiu_byteenable;
    logic             fiu_read;
    logic             fiu_write;
    logic             fiu_waitrequest = 1'b0;
    logic [DW-1:0]    fiu_readdata = '0;
    logic             fiu_readdatavalid = 1'b0;
    logic [OW-1:0]    outstanding_beats;
    logic             err_rsp_underflow;

    int n_pass = 0;
    int n_tot  = 0;

    avalon_mem_if_pipe #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .MAX_ACTIVE_BEATS(MAXB)
    ) dut (
        .clk(clk), .reset(reset),
        .afu_address(afu_address), .afu_burstcount(afu_burstcount),
        .afu_writedata(afu_writedata), .afu_byteenable(afu_byteenable),
        .afu_read(afu_read), .afu_write(afu_write), .afu_waitrequest(afu_waitrequest),
        .afu_readdata(afu_readdata), .afu_readdatavalid(afu_readdatavalid),
        .fiu_address(fiu_address), .fiu_burstcount(fiu_burstcount),
        .fiu_writedata(fiu_writedata), .fiu_byteenable(fiu_byteenable),
        .fiu_read(fiu_read), .fiu_write(fiu_write), .fiu_waitrequest(fiu_waitrequest),
        .fiu_readdata(fiu_readdata), .fiu_readdatavalid(fiu_readdatavalid),
        .outstanding_beats(outstanding_beats), .err_rsp_underflow(err_rsp_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic cmd_t rand_cmd(input bit rd, input int maxbc);
        cmd_t c;
        c.rd   = rd;
        c.wr   = !rd;
        c.addr = AW'($urandom);
        c.bc   = rd ? BW'($urandom_range(1, maxbc)) : BW'(1);
        c.wd   = {$urandom, $urandom};
        c.be   = 8'($urandom);
        return c;
    endfunction

    task automatic drive(input bit valid, input cmd_t c);
        afu_read       = valid && c.rd;
        afu_write      = valid && c.wr;
        afu_address    = c.addr;
        afu_burstcount = c.bc;
        afu_writedata  = c.wd;
        afu_byteenable = c.be;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_tot++; if (afu_waitrequest !== 1'b1) $display("FAIL rst_waitreq: got %0b want 1", afu_waitrequest); else n_pass++;
        n_tot++; if (fiu_read !== 1'b0) $display("FAIL rst_fiu_read: got %0b want 0", fiu_read); else n_pass++;
        n_tot++; if (fiu_write !== 1'b0) $display("FAIL rst_fiu_write: got %0b want 0", fiu_write); else n_pass++;
        n_tot++; if (afu_readdatavalid !== 1'b0) $display("FAIL rst_rdvalid: got %0b want 0", afu_readdatavalid); else n_pass++;
        n_tot++; if (outstanding_beats !== '0) $display("FAIL rst_outstanding: got %0d want 0", outstanding_beats); else n_pass++;
        n_tot++; if (err_rsp_underflow !== 1'b0) $display("FAIL rst_err: got %0b want 0", err_rsp_underflow); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_tot++; if (afu_waitrequest !== 1'b0) $display("FAIL rst_release_waitreq: got %0b want 0", afu_waitrequest); else n_pass++;
    endtask

    task automatic test_single_write();
        cmd_t c;
        c = rand_cmd(1'b0, 1);
        fiu_waitrequest = 1'b0;
        drive(1'b1, c);
        @(negedge clk);
        drive(1'b0, c);
        n_tot++; if (fiu_write !== 1'b1) $display("FAIL sw_fiu_write: got %0b want 1", fiu_write); else n_pass++;
        n_tot++; if (fiu_read !== 1'b0) $display("FAIL sw_fiu_read: got %0b want 0", fiu_read); else n_pass++;
        n_tot++; if (fiu_address !== c.addr) $display("FAIL sw_addr: got %0h want %0h", fiu_address, c.addr); else n_pass++;
        n_tot++; if (fiu_writedata !== c.wd) $display("FAIL sw_wdata: got %0h want %0h", fiu_writedata, c.wd); else n_pass++;
        n_tot++; if (fiu_byteenable !== c.be) $display("FAIL sw_be: got %0h want %0h", fiu_byteenable, c.be); else n_pass++;
        n_tot++; if (afu_waitrequest !== 1'b0) $display("FAIL sw_waitreq: got %0b want 0", afu_waitrequest); else n_pass++;
        @(negedge clk);
        n_tot++; if (fiu_write !== 1'b0) $display("FAIL sw_fiu_write_once: got %0b want 0", fiu_write); else n_pass++;
        n_tot++; if (afu_waitrequest !== 1'b0) $display("FAIL sw_waitreq_after: got %0b want 0", afu_waitrequest); else n_pass++;
    endtask

    task automatic test_back_to_back();
        cmd_t w [3];
        for (int i = 0; i < 3; i++) w[i] = rand_cmd(1'b0, 1);
        fiu_waitrequest = 1'b1;
        drive(1'b1, w[0]);
        @(negedge clk);
        n_tot++; if (afu_waitrequest !== 1'b0) $display("FAIL b2b_wq_after_1: got %0b want 0", afu_waitrequest); else n_pass++;
        drive(1'b1, w[1]);
        @(negedge clk);
        n_tot++; if (afu_waitrequest !== 1'b1) $display("FAIL b2b_wq_after_2: got %0b want 1", afu_waitrequest); else n_pass++;
        drive(1'b1, w[2]);
        @(negedge clk);
        n_tot++; if (afu_waitrequest !== 1'b1) $display("FAIL b2b_wq_held: got %0b want 1", afu_waitrequest); else n_pass++;
        fiu_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) drive(1'b0, w[2]);
            n_tot++; if (fiu_write !== 1'b1) $display("FAIL b2b_write_%0d: got %0b want 1", i, fiu_write); else n_pass++;
            n_tot++; if (fiu_address !== w[i].addr) $display("FAIL b2b_addr_%0d: got %0h want %0h", i, fiu_address, w[i].addr); else n_pass++;
            n_tot++; if (fiu_writedata !== w[i].wd) $display("FAIL b2b_wdata_%0d: got %0h want %0h", i, fiu_writedata, w[i].wd); else n_pass++;
            @(negedge clk);
        end
        n_tot++; if (fiu_write !== 1'b0) $display("FAIL b2b_drained: got %0b want 0", fiu_write); else n_pass++;
    endtask

    task automatic test_credit();
        cmd_t a, b;
        a = rand_cmd(1'b1, 1);
        a.bc = BW'(64);
        b = rand_cmd(1'b1, 1);
        fiu_waitrequest = 1'b0;
        drive(1'b1, a);
        @(negedge clk);
        n_tot++; if (fiu_read !== 1'b1 || fiu_burstcount !== a.bc) $display("FAIL cr_first_read: got rd=%0b bc=%0d want rd=1 bc=64", fiu_read, fiu_burstcount); else n_pass++;
        drive(1'b1, b);
        @(negedge clk);
        drive(1'b0, b);
        n_tot++; if (outstanding_beats !== OW'(64)) $display("FAIL cr_out_64: got %0d want 64", outstanding_beats); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_tot++; if (fiu_read !== 1'b0) $display("FAIL cr_stalled_%0d: got %0b want 0", i, fiu_read); else n_pass++;
            @(negedge clk);
        end
        fiu_readdatavalid = 1'b1;
        fiu_readdata = {$urandom, $urandom};
        @(negedge clk);
        fiu_readdatavalid = 1'b0;
        n_tot++; if (outstanding_beats !== OW'(63)) $display("FAIL cr_out_63: got %0d want 63", outstanding_beats); else n_pass++;
        n_tot++; if (fiu_read !== 1'b1 || fiu_address !== b.addr || fiu_burstcount !== BW'(1))
            $display("FAIL cr_second_read: got rd=%0b addr=%0h bc=%0d want rd=1 addr=%0h bc=1", fiu_read, fiu_address, fiu_burstcount, b.addr); else n_pass++;
        @(negedge clk);
        n_tot++; if (outstanding_beats !== OW'(64)) $display("FAIL cr_out_back_64: got %0d want 64", outstanding_beats); else n_pass++;
        n_tot++; if (fiu_read !== 1'b0) $display("FAIL cr_no_more_read: got %0b want 0", fiu_read); else n_pass++;
        fiu_readdatavalid = 1'b1;
        repeat (64) @(negedge clk);
        fiu_readdatavalid = 1'b0;
        @(negedge clk);
        n_tot++; if (outstanding_beats !== '0) $display("FAIL cr_drain: got %0d want 0", outstanding_beats); else n_pass++;
    endtask

    task automatic test_read_resp();
        cmd_t c;
        logic [DW-1:0] d [4];
        c = rand_cmd(1'b1, 1);
        c.bc = BW'(4);
        for (int k = 0; k < 4; k++) d[k] = {$urandom, $urandom};
        drive(1'b1, c);
        @(negedge clk);
        drive(1'b0, c);
        n_tot++; if (fiu_read !== 1'b1 || fiu_burstcount !== BW'(4)) $display("FAIL rr_issue: got rd=%0b bc=%0d want rd=1 bc=4", fiu_read, fiu_burstcount); else n_pass++;
        @(negedge clk);
        n_tot++; if (outstanding_beats !== OW'(4)) $display("FAIL rr_out_4: got %0d want 4", outstanding_beats); else n_pass++;
        fiu_readdatavalid = 1'b1;
        fiu_readdata = d[0];
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tot++; if (afu_readdatavalid !== 1'b1 || afu_readdata !== d[k])
                $display("FAIL rr_beat_%0d: got v=%0b d=%0h want v=1 d=%0h", k, afu_readdatavalid, afu_readdata, d[k]); else n_pass++;
            if (k < 3) fiu_readdata = d[k+1];
            else fiu_readdatavalid = 1'b0;
        end
        n_tot++; if (outstanding_beats !== '0) $display("FAIL rr_out_0: got %0d want 0", outstanding_beats); else n_pass++;
        @(negedge clk);
        n_tot++; if (afu_readdatavalid !== 1'b0) $display("FAIL rr_valid_drop: got %0b want 0", afu_readdatavalid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        cmd_t w0, w1;
        w0 = rand_cmd(1'b0, 1);
        w1 = rand_cmd(1'b0, 1);
        fiu_waitrequest = 1'b1;
        drive(1'b1, w0);
        @(negedge clk);
        drive(1'b1, w1);
        @(negedge clk);
        drive(1'b0, w1);
        n_tot++; if (afu_waitrequest !== 1'b1) $display("FAIL rm_full: got %0b want 1", afu_waitrequest); else n_pass++;
        reset = 1'b1;
        fiu_waitrequest = 1'b0;
        #1;
        n_tot++; if (fiu_write !== 1'b0) $display("FAIL rm_in_reset_write: got %0b want 0", fiu_write); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        n_tot++; if (afu_waitrequest !== 1'b1) $display("FAIL rm_reset_waitreq: got %0b want 1", afu_waitrequest); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_tot++; if (fiu_write !== 1'b0 || fiu_read !== 1'b0) $display("FAIL rm_dropped_%0d: got wr=%0b rd=%0b want 0 0", i, fiu_write, fiu_read); else n_pass++;
            @(negedge clk);
        end
        n_tot++; if (afu_waitrequest !== 1'b0) $display("FAIL rm_waitreq_after: got %0b want 0", afu_waitrequest); else n_pass++;
        n_tot++; if (err_rsp_underflow !== 1'b0) $display("FAIL rm_err: got %0b want 0", err_rsp_underflow); else n_pass++;
    endtask

    task automatic test_underflow();
        logic [DW-1:0] d;
        d = {$urandom, $urandom};
        fiu_readdatavalid = 1'b1;
        fiu_readdata = d;
        @(negedge clk);
        fiu_readdatavalid = 1'b0;
        n_tot++; if (err_rsp_underflow !== 1'b1) $display("FAIL uf_err_set: got %0b want 1", err_rsp_underflow); else n_pass++;
        n_tot++; if (outstanding_beats !== '0) $display("FAIL uf_out_hold: got %0d want 0", outstanding_beats); else n_pass++;
        n_tot++; if (afu_readdatavalid !== 1'b1 || afu_readdata !== d) $display("FAIL uf_forward: got v=%0b d=%0h want v=1 d=%0h", afu_readdatavalid, afu_readdata, d); else n_pass++;
        repeat (3) @(negedge clk);
        n_tot++; if (err_rsp_underflow !== 1'b1) $display("FAIL uf_sticky: got %0b want 1", err_rsp_underflow); else n_pass++;
        n_tot++; if (outstanding_beats !== '0) $display("FAIL uf_out_still0: got %0d want 0", outstanding_beats); else n_pass++;
    endtask

    task automatic test_random();
        cmd_t          mq [$];
        cmd_t          c;
        int            m_out;
        bit            m_wq;
        bit            exp_rv;
        logic [DW-1:0] exp_rd;
        bit            e_rd, e_wr, cv, beat, pop;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tot++; if (err_rsp_underflow !== 1'b0) $display("FAIL rnd_err_cleared: got %0b want 0", err_rsp_underflow); else n_pass++;
        m_out  = 0;
        m_wq   = 1'b0;
        exp_rv = 1'b0;
        exp_rd = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            n_tot++; if (afu_waitrequest !== m_wq) $display("FAIL rnd_waitreq c%0d: got %0b want %0b", cyc, afu_waitrequest, m_wq); else n_pass++;
            n_tot++; if (int'(outstanding_beats) != m_out) $display("FAIL rnd_outstanding c%0d: got %0d want %0d", cyc, outstanding_beats, m_out); else n_pass++;
            n_tot++; if (afu_readdatavalid !== exp_rv || (exp_rv && afu_readdata !== exp_rd))
                $display("FAIL rnd_resp c%0d: got v=%0b d=%0h want v=%0b d=%0h", cyc, afu_readdatavalid, afu_readdata, exp_rv, exp_rd); else n_pass++;
            e_rd = 1'b0;
            e_wr = 1'b0;
            if (mq.size() > 0) begin
                if (mq[0].wr) e_wr = 1'b1;
                else if (m_out + int'(mq[0].bc) <= MAXB) e_rd = 1'b1;
            end
            n_tot++; if (fiu_read !== e_rd || fiu_write !== e_wr)
                $display("FAIL rnd_strobe c%0d: got rd=%0b wr=%0b want rd=%0b wr=%0b", cyc, fiu_read, fiu_write, e_rd, e_wr); else n_pass++;
            if (e_rd || e_wr) begin
                n_tot++; if (fiu_address !== mq[0].addr || fiu_burstcount !== mq[0].bc)
                    $display("FAIL rnd_fields c%0d: got a=%0h bc=%0d want a=%0h bc=%0d", cyc, fiu_address, fiu_burstcount, mq[0].addr, mq[0].bc); else n_pass++;
            end
            if (e_wr) begin
                n_tot++; if (fiu_writedata !== mq[0].wd || fiu_byteenable !== mq[0].be)
                    $display("FAIL rnd_wdata c%0d: got %0h/%0h want %0h/%0h", cyc, fiu_writedata, fiu_byteenable, mq[0].wd, mq[0].be); else n_pass++;
            end
            cv = ($urandom_range(0, 9) < 6);
            c  = rand_cmd($urandom_range(0, 1) == 1, 12);
            drive(cv, c);
            fiu_waitrequest   = ($urandom_range(0, 3) == 0);
            beat              = (m_out > 0) && ($urandom_range(0, 2) != 0);
            fiu_readdatavalid = beat;
            fiu_readdata      = {$urandom, $urandom};
            pop = (e_rd || e_wr) && !fiu_waitrequest;
            if (pop) begin
                if (e_rd) m_out += int'(mq[0].bc);
                void'(mq.pop_front());
            end
            if (beat) m_out -= 1;
            if (cv && !m_wq) mq.push_back(c);
            m_wq   = (mq.size() == 2);
            exp_rv = beat;
            exp_rd = fiu_readdata;
            @(negedge clk);
        end
        drive(1'b0, c);
        fiu_readdatavalid = 1'b0;
        fiu_waitrequest = 1'b0;
        n_tot++; if (err_rsp_underflow !== 1'b0) $display("FAIL rnd_no_underflow: got %0b want 0", err_rsp_underflow); else n_pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_write();
        test_back_to_back();
        test_credit();
        test_read_resp();
        test_reset_mid();
        test_underflow();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/avalon_mem_if_pipe.md
AVALON_MEM_IF_PIPE -- requirements
Module: avalon_mem_if_pipe

Interface
REQ-001 Parameter ADDR_WIDTH, default 27, word address width on both sides.
REQ-002 Parameter DATA_WIDTH, default 512, read/write data width; byteenable width is DATA_WIDTH/8.
REQ-003 Parameter BURST_CNT_WIDTH, default 7, burstcount width; legal burstcount is 1..2^(BURST_CNT_WIDTH-1).
REQ-004 Parameter MAX_ACTIVE_BEATS, default 256, read-beat credit limit; it SHALL be at least 2^(BURST_CNT_WIDTH-1), otherwise elaboration fails.
REQ-005 Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.

Ports (name, direction, width, meaning):
REQ-006 clk  in  1  sole clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 afu_address/afu_burstcount/afu_writedata/afu_byteenable  in  ADDR_WIDTH/BURST_CNT_WIDTH/DATA_WIDTH/DATA_WIDTH/8  AFU command fields.
REQ-009 afu_read, afu_write  in  1 each  AFU command strobes, mutually exclusive.
REQ-010 afu_waitrequest  out  1  registered backpressure to the AFU.
REQ-011 afu_readdata  out  DATA_WIDTH  read data; afu_readdatavalid  out  1  read data qualifier.
REQ-012 fiu_address/fiu_burstcount/fiu_writedata/fiu_byteenable/fiu_read/fiu_write  out  widths as in REQ-008/009  command to the FIU.
REQ-013 fiu_waitrequest  in  1  FIU backpressure; fiu_readdata  in  DATA_WIDTH; fiu_readdatavalid  in  1.
REQ-014 outstanding_beats  out  clog2(MAX_ACTIVE_BEATS+1)  read beats issued to the FIU and not yet returned.
REQ-015 err_rsp_underflow  out  1  sticky: a read beat arrived with outstanding_beats==0.

Function
REQ-016 AFU accept: a command is accepted when (afu_read|afu_write) & !afu_waitrequest; each write beat is a separate command.
REQ-017 The command path SHALL be a 2-entry in-order buffer holding {read, write, address, burstcount, writedata, byteenable}.
REQ-018 afu_waitrequest SHALL be a flop equal to (next buffer occupancy == 2); an occupancy of 0 or 1 gives 0.
REQ-019 FIU issue: the head entry drives fiu_* and the matching fiu_read/fiu_write is asserted; an entry is popped on fiu_(read|write) & !fiu_waitrequest.
REQ-020 Latency: a command accepted in cycle T with an empty buffer SHALL appear on the FIU in cycle T+1.
REQ-021 Full throughput: one command per cycle SHALL be sustained while fiu_waitrequest=0.
REQ-022 Read credit: a head read SHALL NOT be asserted until outstanding_beats + burstcount <= MAX_ACTIVE_BEATS.
REQ-023 Once asserted, fiu_read and all fiu_* fields SHALL hold stable until accepted.
REQ-024 Writes are not credit-limited; a credit-stalled read head blocks all later entries, so ordering is preserved.
REQ-025 outstanding_beats SHALL add burstcount on FIU read acceptance and subtract 1 per fiu_readdatavalid; both may occur in the same cycle (net update).
REQ-026 On fiu_readdatavalid with outstanding_beats==0, the counter SHALL hold at 0 and err_rsp_underflow SHALL set.
REQ-027 Response path: afu_readdatavalid/afu_readdata SHALL be fiu_readdatavalid/fiu_readdata registered, exactly 1 cycle of latency, never backpressured.
REQ-028 Simultaneous push and pop at occupancy 2 is impossible (waitrequest=1); at occupancy 1 it leaves occupancy 1.

Reset
REQ-029 While reset=1: buffer emptied, fiu_read=fiu_write=0, afu_readdatavalid=0, outstanding_beats=0, err_rsp_underflow=0, afu_waitrequest=1.
REQ-030 afu_waitrequest SHALL be 0 in the first cycle after reset deasserts.
REQ-031 Reset mid-operation SHALL drop buffered commands without issuing them; post-reset stray beats are forwarded and handled per REQ-026.

Verification
REQ-032 Single write, fiu_waitrequest=0, accepted cycle 5 -> fiu_write=1 with identical fields in cycle 6 only; afu_waitrequest stays 0.
REQ-033 fiu_waitrequest=1 held, AFU issues 3 back-to-back writes -> 2 accepted, afu_waitrequest=1 from the cycle after the 2nd accept; release -> all 3 appear in order, one per cycle.
REQ-034 MAX_ACTIVE_BEATS=64, BURST_CNT_WIDTH=7: read burst 64 accepted, then read burst 1 -> 2nd fiu_read stays low until 1 beat returns; outstanding_beats goes 64, 63, then 64.
REQ-035 Accept read burst 4, FIU returns 4 beats in cycles 10-13 -> afu_readdatavalid in cycles 11-14 with matching data; outstanding_beats=0 after cycle 13.
REQ-036 Reset asserted for 1 cycle with 2 buffered commands -> neither issued; err_rsp_underflow=0.
REQ-037 Reset, then inject fiu_readdatavalid -> err_rsp_underflow=1 (sticky) and outstanding_beats=0.
